// File: rtl/pdm_cic_decim.sv
// ----------------------------------------------------------------------------
// pdm_cic_decim
//
// PDM microphone front end plus the first decimation stage of the acoustic
// capture chain. Generates the microphone bit clock, resynchronises the 1-bit
// PDM stream, and runs a 4th-order CIC decimator (R = 16, M = 1) with
// pipelined integrators. Produces signed Q0.17 samples with a one-cycle valid
// strobe for the following half-band stage.
//
// Ports:
//   clk      in   1   system clock (single domain)
//   rst      in   1   asynchronous, active-low reset
//   pdm_in   in   1   raw microphone data, asynchronous to clk
//   pdm_clk  out  1   microphone bit clock, registered, 50 % duty
//   y_out    out  17  signed Q0.17 decimated sample, holds between strobes
//   y_valid  out  1   one-cycle pulse marking a new y_out
//
// Parameters:
//   CLK_DIV  system clocks per pdm_clk period (even, >= 8)
//   CH       0: sample just before pdm_clk falls; 1: just before it rises
//
// Handshake: y_valid is a pure strobe with no back-pressure; the consumer
// must take y_out on every cycle y_valid is high.
// ----------------------------------------------------------------------------
module pdm_cic_decim #(
    parameter int CLK_DIV = 32,
    parameter int CH      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pdm_in,
    output logic        pdm_clk,
    output logic [16:0] y_out,
    output logic        y_valid
);

    localparam int DECIM = 16;
    localparam int ORDER = 4;
    localparam int W     = 18;

    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DECIM);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
    // Channel slot: CH=0 samples at the end of the high phase, CH=1 at the
    // end of the low phase.
    localparam logic [CW-1:0] TICK_AT  = (CH == 1) ? CW'(CLK_DIV / 2 - 1)
                                                   : CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);

    // Only reachable with a full-scale positive input (+1 * R^N = 65536),
    // which does not fit Q0.17 and is clipped by one LSB.
    localparam logic [W-1:0]  POS_FS   = 18'h10000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [W-1:0]  integ_q [ORDER];
    logic [W-1:0]  integ_d [ORDER];
    logic [W-1:0]  s0_q, s0_d;
    logic [W-1:0]  comb_q  [ORDER];
    logic [W-1:0]  comb_d  [ORDER];
    logic [W-1:0]  dly_q   [ORDER];
    logic [W-1:0]  dly_d   [ORDER];
    logic [ORDER:0] vld_q, vld_d;
    logic [16:0]   y_q, y_d;
    logic          y_valid_q, y_valid_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          tick;
    logic          capture;
    logic [W-1:0]  x;
    logic [W-1:0]  comb_in [ORDER];

    assign tick    = (cnt_q == TICK_AT);
    assign capture = tick && (dcnt_q == DCNT_LAST);
    // PDM bit mapped to +1 / -1 in two's complement.
    assign x       = sync_q[1] ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    always_comb begin
        // Divider and bit clock; pdm_clk is registered from the current
        // count so it changes exactly at the half-period boundaries.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
        pdm_clk_d = (cnt_q >= CNT_HALF);

        sync_d = {sync_q[0], pdm_in};

        // Integrators: every stage reads the pre-tick value of its
        // predecessor, so the chain is fully pipelined. Sums wrap mod 2^W.
        integ_d = integ_q;
        dcnt_d  = dcnt_q;
        s0_d    = s0_q;
        if (tick) begin
            integ_d[0] = integ_q[0] + x;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            dcnt_d = dcnt_q + DW'(1);
            if (dcnt_q == DCNT_LAST) begin
                s0_d = integ_q[ORDER-1];
            end
        end

        // Comb stage j advances only when its input carries a fresh sample,
        // which the vld_q shift register tracks one stage per clock.
        vld_d = {vld_q[ORDER-1:0], capture};

        comb_in[0] = s0_q;
        for (int j = 1; j < ORDER; j++) begin
            comb_in[j] = comb_q[j-1];
        end

        comb_d = comb_q;
        dly_d  = dly_q;
        for (int j = 0; j < ORDER; j++) begin
            if (vld_q[j]) begin
                comb_d[j] = comb_in[j] - dly_q[j];
                dly_d[j]  = comb_in[j];
            end
        end

        y_d       = y_q;
        y_valid_d = vld_q[ORDER];
        if (vld_q[ORDER]) begin
            if (comb_q[ORDER-1] == POS_FS) begin
                y_d = 17'h0FFFF;
            end else begin
                y_d = comb_q[ORDER-1][16:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
            sync_q    <= '0;
            dcnt_q    <= '0;
            s0_q      <= '0;
            vld_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            pdm_clk_q <= pdm_clk_d;
            sync_q    <= sync_d;
            dcnt_q    <= dcnt_d;
            s0_q      <= s0_d;
            vld_q     <= vld_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                comb_q[k]  <= comb_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

    assign pdm_clk = pdm_clk_q;
    assign y_out   = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// ----------------------------------------------------------------------------
// Bench for pdm_cic_decim. Three instances share clock, reset and pdm_in:
//   0: CLK_DIV=32, CH=0    1: CLK_DIV=32, CH=1    2: CLK_DIV=8, CH=0
// The reference is the CIC impulse response (sum of 16 ones)^4 applied as a
// direct convolution to the +/-1 samples each instance sees, with a 4-tick
// delay from the pipelined integrators and pre-update capture.
// ----------------------------------------------------------------------------
module tb_pdm_cic_decim;

  localparam int NI = 3;
  localparam int D_P  [NI] = '{32, 32, 8};
  localparam int CH_P [NI] = '{0, 1, 0};
  localparam int HMAX = 40000;
  localparam int NTAP = 61;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pdm_in = 1'b0;

  always #5 clk = ~clk;

  logic [NI-1:0] pclk_w;
  logic [NI-1:0] yv_w;
  logic [16:0]   y_w [NI];

  pdm_cic_decim #(.CLK_DIV(32), .CH(0)) dut0 (
    .clk(clk), .rst(rst), .pdm_in(pdm_in),
    .pdm_clk(pclk_w[0]), .y_out(y_w[0]), .y_valid(yv_w[0])
  );
  pdm_cic_decim #(.CLK_DIV(32), .CH(1)) dut1 (
    .clk(clk), .rst(rst), .pdm_in(pdm_in),
    .pdm_clk(pclk_w[1]), .y_out(y_w[1]), .y_valid(yv_w[1])
  );
  pdm_cic_decim #(.CLK_DIV(8), .CH(0)) dut2 (
    .clk(clk), .rst(rst), .pdm_in(pdm_in),
    .pdm_clk(pclk_w[2]), .y_out(y_w[2]), .y_valid(yv_w[2])
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;      // index of the clock edge since reset release
  int phase = 0;    // 0 random, 1 all ones, 2 all zeros, 3 idle tone
  int h [NTAP];
  bit pin_hist [HMAX];  // pdm_in value present at each edge
  logic [16:0] hold_exp [NI];
  bit hold_known [NI];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output sample m is captured on tick 16m+15; the integrator pipeline
  // delays the input by 4 ticks, so the window ends at tick 16m+11.
  function automatic logic [16:0] model_y(input int i, input int m);
    int d, toff, n, t, e, acc;
    d = D_P[i];
    toff = (CH_P[i] == 1) ? d / 2 - 1 : d - 1;
    n = 16 * m + 15;
    acc = 0;
    for (int j = 0; j < NTAP; j++) begin
      t = n - 4 - j;
      if (t >= 0) begin
        e = toff + t * d - 2;  // pin value two cycles before the tick
        acc += h[j] * (pin_hist[e] ? 1 : -1);
      end
    end
    if (acc == 65536) acc = 65535;
    return acc[16:0];
  endfunction

  task automatic check_inst(input int i);
    int d, first, m;
    bit exp_v;
    logic [16:0] e;
    d = D_P[i];
    first = (CH_P[i] == 1) ? 15 * d + d / 2 + 4 : 16 * d + 4;
    if (!rst) begin
      chk($sformatf("rst_pdm_clk[%0d]", i), int'(pclk_w[i]), 0);
      chk($sformatf("rst_y_out[%0d]", i), int'(y_w[i]), 0);
      chk($sformatf("rst_y_valid[%0d]", i), int'(yv_w[i]), 0);
      hold_exp[i] = '0;
      hold_known[i] = 1'b1;
    end else begin
      chk($sformatf("pdm_clk[%0d]", i), int'(pclk_w[i]), int'((cyc % d) >= d / 2));
      exp_v = (cyc >= first) && (((cyc - first) % (16 * d)) == 0);
      chk($sformatf("y_valid[%0d]", i), int'(yv_w[i]), int'(exp_v));
      if (exp_v) begin
        m = (cyc - first) / (16 * d);
        if (m >= 5) begin
          e = model_y(i, m);
          chk($sformatf("y_out[%0d] m=%0d", i, m), int'(y_w[i]), int'(e));
          if (phase == 1) chk($sformatf("ones_lit[%0d]", i), int'(y_w[i]), 32'h0FFFF);
          if (phase == 2) chk($sformatf("zeros_lit[%0d]", i), int'(y_w[i]), 32'h10000);
          if (phase == 3 && d == 32) chk($sformatf("idle_lit[%0d]", i), int'(y_w[i]), 0);
          hold_exp[i] = e;
          hold_known[i] = 1'b1;
        end else begin
          hold_known[i] = 1'b0;  // fill transient, value not specified
        end
      end else if (hold_known[i]) begin
        chk($sformatf("y_hold[%0d]", i), int'(y_w[i]), int'(hold_exp[i]));
      end
    end
  endtask

  // compare process: one pass per clock, 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) check_inst(i);
    if (rst) cyc++;
  end

  // driver tasks (entered and left on a falling edge)
  task automatic run_phase(input int p, input int ncyc);
    bit v;
    phase = p;
    cyc = 0;
    rst = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      case (p)
        0: v = 1'($urandom_range(0, 1));
        1: v = 1'b1;
        2: v = 1'b0;
        default: v = 1'((k / 32) % 2);
      endcase
      pdm_in = v;
      pin_hist[k] = v;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("async_pdm_clk[%0d]", i), int'(pclk_w[i]), 0);
      chk($sformatf("async_y_out[%0d]", i), int'(y_w[i]), 0);
      chk($sformatf("async_y_valid[%0d]", i), int'(yv_w[i]), 0);
    end
    repeat (3) begin
      @(negedge clk);
      pdm_in = ~pdm_in;
    end
  endtask

  initial begin
    int nh [NTAP];
    int hsum;

    // impulse response: four cascaded 16-tap boxcars
    foreach (h[k]) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < NTAP; k++) begin
        nh[k] = 0;
        for (int q = 0; q < 16; q++) if (k - q >= 0) nh[k] += h[k - q];
      end
      h = nh;
    end
    hsum = 0;
    foreach (h[k]) hsum += h[k];
    chk("model_h0", h[0], 1);
    chk("model_h1", h[1], 4);
    chk("model_h30", h[30], 2736);
    chk("model_h60", h[60], 1);
    chk("model_gain", hsum, 65536);

    // reset held 10 cycles with the pin toggling
    rst = 1'b0;
    pdm_in = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pdm_in = ~pdm_in;
    end

    // random stream; ends with instance 0 at dcnt = 9 (1033 ticks)
    run_phase(0, 32768 + 9 * 32 + 10);
    do_reset();
    run_phase(1, 16000);
    do_reset();
    run_phase(2, 6000);
    do_reset();
    run_phase(3, 6000);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
